atto_bus_arbiter: RTL and testbench
===================================

# atto_bus_arbiter

Two-master arbiter and sequencer for the attocore external memory bus. It sits between the attocore fetch/load/store port (master 0) and a secondary master such as a DMA or debug loader (master 1), and shares the single 16-bit address / 8-bit data memory bus between them. It applies round-robin arbitration, latches the winning request, drives the bus for a programmable number of wait states, and returns read data with a one-cycle acknowledge.

## Interface
- WAIT_CYCLES, 0, extra memory wait states per access (0..15)
- CNT_W, 4, width of wait-state counter; must hold WAIT_CYCLES
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- m0_req  in  1  master 0 request, held until m0_ack
- m0_we  in  1  master 0 direction, 1=write, 0=read
- m0_addr  in  16  master 0 address
- m0_wdata  in  8  master 0 write data
- m0_ack  out  1  one-cycle completion pulse to master 0
- m0_rdata  out  8  master 0 read data, valid while m0_ack=1 and held until next master-0 read
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as master 0, for master 1
- address_bus  out  16  memory address
- data_dir  out  1  1=read cycle (memory drives data), 0=write or idle
- data_out  out  8  write data to memory
- data_oe  out  1  1=data_out drives the shared data bus; the tristate is built outside this block
- data_in  in  8  read data from memory
- busy  out  1  1 while a transaction is in ACCESS or DONE

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: samples m0_req and m1_req.
  - Exactly one request is high: that master is granted.
  - Both are high: the master not granted last wins (round-robin).
  - On grant, the block latches grant, we, addr, wdata and drives the bus. address_bus<=addr, data_dir<=~we, data_out<=wdata (writes), data_oe<=we. The wait counter loads WAIT_CYCLES and the state goes to ACCESS.
  - No request: stays in IDLE, bus outputs unchanged except data_oe=0 and data_dir=0.
- ACCESS: bus outputs are held stable.
  - counter!=0: decrement.
  - counter==0 and read: the granted rdata register captures data_in.
  - counter==0: the granted ack is set, last_grant is updated, and the state goes to DONE.
- DONE: the granted ack is high for exactly this cycle, and busy=1. At the ending edge: ack<=0, data_oe<=0, data_dir<=0, then IDLE.
- Requests are sampled only in IDLE. Changes to req, we, addr or wdata during ACCESS or DONE are ignored. The inputs of the non-granted master are ignored.
- A master drops req in the cycle after it sees ack. If req is still high in IDLE, that is a new transaction.
- The non-granted master's ack is never asserted. m0_ack and m1_ack are never high together.
- Reset values:
  - address_bus=0, data_dir=0, data_out=0, data_oe=0, busy=0
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0
  - state=IDLE, counter=0, last_grant=1, so master 0 wins the first tie.
- Reset mid-transaction: on the next edge the block is in IDLE with all reset values. No ack is issued for the aborted access and rdata is not updated.

## Timing
- Cycle n is IDLE with req high. Cycles n+1..n+1+WAIT_CYCLES are ACCESS. Cycle n+2+WAIT_CYCLES is DONE with ack=1.
- Request-to-ack latency is WAIT_CYCLES+2 cycles. Transaction period is WAIT_CYCLES+3 cycles, including the IDLE arbitration cycle.
- Read data is captured at the last ACCESS edge. data_in must be valid in the final ACCESS cycle.
- Writes: data_oe=1 for all ACCESS cycles plus the DONE cycle, with address and data stable throughout.
- With continuous requests from both masters, grants alternate strictly 0,1,0,1. Neither master waits more than one transaction.

## Test plan
- Single read, WAIT_CYCLES=0: m0 reads 0x1234 with data_in=0xA5 -> address_bus=0x1234 and data_dir=1 at cycle 1; m0_ack=1 and m0_rdata=0xA5 at cycle 2; m1_ack stays 0.
- Write with WAIT_CYCLES=3: m1 writes 0x5A to 0xBEEF -> data_oe=1 and data_out=0x5A for 5 cycles; m1_ack at cycle 5; memory model sees exactly one write.
- Simultaneous requests after reset, both held for 4 transactions -> grant order 0,1,0,1; one ack per transaction, 3 cycles apart at WAIT_CYCLES=0.
- Mid-transaction input change: m0 changes addr from 0x0010 to 0x0020 during ACCESS -> address_bus stays 0x0010 until DONE.
- Reset asserted in ACCESS -> next cycle all outputs at reset values, no ack, last_grant=1; the next tie grants m0.
- Back-to-back single master: m0 holds req through ack (treated as new request) -> second transaction starts in the IDLE cycle after DONE with fresh addr.

Source files
------------

// File: rtl/atto_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the attocore external memory bus.
// Grants in IDLE, holds the bus for WAIT_CYCLES+1 ACCESS cycles, then pulses ack in DONE.
module atto_bus_arbiter #(
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic [15:0] address_bus,
  output logic        data_dir,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic             grant;
  logic             last_grant;
  logic             we_q;

  logic             any_req;
  logic             pick;
  logic             sel_we;
  logic [15:0]      sel_addr;
  logic [7:0]       sel_wdata;

  // On a tie the master that did not win last time is picked.
  always_comb begin
    any_req = m0_req | m1_req;
    pick    = 1'b0;
    if (m0_req && m1_req) begin
      pick = ~last_grant;
    end else if (m1_req) begin
      pick = 1'b1;
    end
    sel_we    = pick ? m1_we    : m0_we;
    sel_addr  = pick ? m1_addr  : m0_addr;
    sel_wdata = pick ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      we_q        <= 1'b0;
      address_bus <= '0;
      data_dir    <= 1'b0;
      data_out    <= '0;
      data_oe     <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant       <= pick;
            we_q        <= sel_we;
            address_bus <= sel_addr;
            data_dir    <= ~sel_we;
            data_oe     <= sel_we;
            count       <= CNT_W'(WAIT_CYCLES);
            if (sel_we) begin
              data_out <= sel_wdata;
            end
          end else begin
            data_oe  <= 1'b0;
            data_dir <= 1'b0;
          end
        end
        ACCESS: begin
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            // Final ACCESS edge: memory data is valid now, so capture and complete.
            if (!we_q) begin
              if (grant) begin
                m1_rdata <= data_in;
              end else begin
                m0_rdata <= data_in;
              end
            end
            if (grant) begin
              m1_ack <= 1'b1;
            end else begin
              m0_ack <= 1'b1;
            end
            last_grant <= grant;
          end
        end
        DONE: begin
          m0_ack   <= 1'b0;
          m1_ack   <= 1'b0;
          data_oe  <= 1'b0;
          data_dir <= 1'b0;
        end
        default: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atto_bus_arbiter.sv
// Bench for atto_bus_arbiter: one instance with WAIT_CYCLES=0 and one with 3, sharing master inputs.
// The idle instance is held in reset while the other is exercised.
module tb_atto_bus_arbiter;

  typedef struct {
    bit          master;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        exp_dir;
    logic        exp_oe;
    logic [7:0]  exp_rdata;
  } vec_t;

  typedef struct {
    bit          master;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  rdata;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst0  = 1'b1;
  logic        rst3  = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic [7:0]  m0_wdata = '0, m1_wdata = '0;

  logic        m0_ack0, m1_ack0, data_dir0, data_oe0, busy0;
  logic [7:0]  m0_rdata0, m1_rdata0, data_out0, data_in0;
  logic [15:0] address_bus0;
  logic        m0_ack3, m1_ack3, data_dir3, data_oe3, busy3;
  logic [7:0]  m0_rdata3, m1_rdata3, data_out3, data_in3;
  logic [15:0] address_bus3;

  int   tests = 0;
  int   fails = 0;
  int   wr_cnt3 = 0;
  logic oe3_prev = 1'b0;
  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;
  vec_t vecs[6];

  always #5 clock = ~clock;

  // Memory model: read data is a fixed function of the address on the bus.
  function automatic logic [7:0] rd_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h83;
  endfunction

  assign data_in0 = rd_val(address_bus0);
  assign data_in3 = rd_val(address_bus3);

  atto_bus_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
    .clock(clock), .reset(rst0),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack0), .m0_rdata(m0_rdata0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack0), .m1_rdata(m1_rdata0),
    .address_bus(address_bus0), .data_dir(data_dir0), .data_out(data_out0),
    .data_oe(data_oe0), .data_in(data_in0), .busy(busy0)
  );

  atto_bus_arbiter #(.WAIT_CYCLES(3), .CNT_W(4)) dut3 (
    .clock(clock), .reset(rst3),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack3), .m0_rdata(m0_rdata3),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack3), .m1_rdata(m1_rdata3),
    .address_bus(address_bus3), .data_dir(data_dir3), .data_out(data_out3),
    .data_oe(data_oe3), .data_in(data_in3), .busy(busy3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic a0, input logic a1,
                       input logic [15:0] ab, input logic [7:0] r0, input logic [7:0] r1);
    check({tag, "_ack_master"}, 32'({a1, a0}), e.master ? 32'd2 : 32'd1);
    check({tag, "_ack_addr"}, 32'(ab), 32'(e.addr));
    if (!e.we) begin
      check({tag, "_rdata"}, 32'(e.master ? r1 : r0), 32'(e.rdata));
    end
  endtask

  // Scoreboard: every ack must match the oldest outstanding expected transaction.
  always @(negedge clock) begin
    if (m0_ack0 || m1_ack0) begin
      if (q0.size() == 0) begin
        check("d0_unexpected_ack", 32'({m0_ack0, m1_ack0}), 32'd0);
      end else begin
        e0 = q0.pop_front();
        score("d0", e0, m0_ack0, m1_ack0, address_bus0, m0_rdata0, m1_rdata0);
      end
    end
    if (m0_ack3 || m1_ack3) begin
      if (q3.size() == 0) begin
        check("d3_unexpected_ack", 32'({m0_ack3, m1_ack3}), 32'd0);
      end else begin
        e3 = q3.pop_front();
        score("d3", e3, m0_ack3, m1_ack3, address_bus3, m0_rdata3, m1_rdata3);
      end
    end
    if (data_oe3 && !oe3_prev) wr_cnt3++;
    oe3_prev = data_oe3;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drive(input bit m, input logic req, input logic we,
                       input logic [15:0] addr, input logic [7:0] wdata);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic push(input bit dut, input bit m, input bit we,
                      input logic [15:0] addr, input logic [7:0] rdata);
    exp_t e;
    e.master = m; e.we = we; e.addr = addr; e.rdata = rdata;
    if (dut) q3.push_back(e);
    else     q0.push_back(e);
  endtask

  // Reset both instances, then release only the one under test.
  task automatic reset_only(input bit which);
    drive(0, 0, 0, 16'h0, 8'h0);
    drive(1, 0, 0, 16'h0, 8'h0);
    rst0 = 1'b1; rst3 = 1'b1;
    repeat (2) tick();
    if (which) rst3 = 1'b0;
    else       rst0 = 1'b0;
    tick();
  endtask

  initial begin
    int acks, last, cyc, oe_cnt;
    vec_t v;

    vecs[0] = '{0, 0, 16'h1234, 8'h00, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{1, 0, 16'h00FF, 8'h00, 1'b1, 1'b0, 8'h7C};
    vecs[2] = '{0, 1, 16'hBEEF, 8'h3C, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{1, 1, 16'h0001, 8'hC3, 1'b0, 1'b1, 8'h00};
    vecs[4] = '{0, 0, 16'hFFFF, 8'h00, 1'b1, 1'b0, 8'h83};
    vecs[5] = '{1, 0, 16'h8000, 8'h00, 1'b1, 1'b0, 8'h03};

    // Reset values of both instances
    repeat (3) tick();
    rst0 = 1'b0; rst3 = 1'b0;
    tick();
    check("rst_addr0", 32'(address_bus0), 32'd0);
    check("rst_dir0",  32'(data_dir0), 32'd0);
    check("rst_out0",  32'(data_out0), 32'd0);
    check("rst_oe0",   32'(data_oe0), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_ack0",  32'({m0_ack0, m1_ack0}), 32'd0);
    check("rst_rd0",   32'({m0_rdata0, m1_rdata0}), 32'd0);
    check("rst_addr3", 32'(address_bus3), 32'd0);
    check("rst_ctl3",  32'({data_dir3, data_oe3, busy3, m0_ack3, m1_ack3}), 32'd0);
    check("rst_dat3",  32'({data_out3, m0_rdata3, m1_rdata3}), 32'd0);

    // Single transactions at WAIT_CYCLES=0
    reset_only(0);
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      drive(v.master, 1, v.we, v.addr, v.wdata);
      push(0, v.master, v.we, v.addr, v.exp_rdata);
      tick();
      check("vec_addr", 32'(address_bus0), 32'(v.addr));
      check("vec_dir",  32'(data_dir0), 32'(v.exp_dir));
      check("vec_oe",   32'(data_oe0), 32'(v.exp_oe));
      check("vec_busy_access", 32'(busy0), 32'd1);
      check("vec_no_early_ack", 32'({m0_ack0, m1_ack0}), 32'd0);
      if (v.we) check("vec_wdata", 32'(data_out0), 32'(v.wdata));
      tick();
      check("vec_ack", 32'({m1_ack0, m0_ack0}), v.master ? 32'd2 : 32'd1);
      check("vec_busy_done", 32'(busy0), 32'd1);
      drive(v.master, 0, 0, 16'h0, 8'h0);
      tick();
      check("vec_idle", 32'({busy0, data_oe0, data_dir0}), 32'd0);
      check("vec_idle_addr_held", 32'(address_bus0), 32'(v.addr));
    end
    check("rdata_hold_m0", 32'(m0_rdata0), 32'h83);
    check("rdata_hold_m1", 32'(m1_rdata0), 32'h03);

    // Write at WAIT_CYCLES=3 by master 1
    reset_only(1);
    wr_cnt3 = 0;
    oe_cnt  = 0;
    drive(1, 1, 1, 16'hBEEF, 8'h5A);
    push(1, 1, 1, 16'hBEEF, 8'h00);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (data_oe3 && data_out3 == 8'h5A && address_bus3 == 16'hBEEF) oe_cnt++;
      check("w3_ack_timing", 32'(m1_ack3), 32'(c == 5));
      if (c == 5) drive(1, 0, 0, 16'h0, 8'h0);
    end
    check("w3_oe_cycles", 32'(oe_cnt), 32'd5);
    check("w3_write_count", 32'(wr_cnt3), 32'd1);

    // Continuous requests from both masters at WAIT_CYCLES=0
    reset_only(0);
    drive(0, 1, 0, 16'h0A0B, 8'h00);
    drive(1, 1, 0, 16'h0B0C, 8'h00);
    for (int k = 0; k < 2; k++) begin
      push(0, 0, 0, 16'h0A0B, 8'h82);
      push(0, 1, 0, 16'h0B0C, 8'h84);
    end
    acks = 0; last = 0; cyc = 0;
    while (acks < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (m0_ack0 || m1_ack0) begin
        acks++;
        if (acks > 1) check("rr_ack_gap", 32'(cyc - last), 32'd3);
        else          check("rr_first_latency", 32'(cyc), 32'd2);
        last = cyc;
        if (acks == 4) begin
          drive(0, 0, 0, 16'h0, 8'h0);
          drive(1, 0, 0, 16'h0, 8'h0);
        end
      end
    end
    check("rr_ack_count", 32'(acks), 32'd4);
    tick();

    // Inputs changed during ACCESS are ignored
    reset_only(1);
    drive(0, 1, 0, 16'h0010, 8'h00);
    push(1, 0, 0, 16'h0010, 8'h93);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("mid_addr_stable", 32'(address_bus3), 32'h0010);
      check("mid_oe_stable", 32'(data_oe3), 32'd0);
      if (c == 1) drive(0, 1, 1, 16'h0020, 8'hEE);
      if (c == 5) drive(0, 0, 0, 16'h0, 8'h0);
    end
    tick();

    // Reset during ACCESS aborts the access and restores the tie-break
    reset_only(1);
    drive(0, 1, 0, 16'h0010, 8'h00);
    push(1, 0, 0, 16'h0010, 8'h93);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) drive(0, 0, 0, 16'h0, 8'h0);
    end
    tick();
    drive(1, 1, 0, 16'h2222, 8'h00);
    tick();
    check("rstmid_in_access", 32'({busy3, address_bus3}), 32'h1_2222);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    check("rstmid_addr", 32'(address_bus3), 32'd0);
    check("rstmid_ctl", 32'({data_dir3, data_oe3, busy3, m0_ack3, m1_ack3}), 32'd0);
    check("rstmid_dat", 32'({data_out3, m0_rdata3, m1_rdata3}), 32'd0);
    drive(0, 1, 0, 16'h3344, 8'h00);
    push(1, 0, 0, 16'h3344, 8'hF4);
    push(1, 1, 0, 16'h2222, 8'h83);
    acks = 0; cyc = 0;
    while (acks < 2 && cyc < 40) begin
      tick();
      cyc++;
      if (m0_ack3 || m1_ack3) begin
        acks++;
        if (acks == 1) begin
          check("rstmid_tie_m0", 32'({m1_ack3, m0_ack3}), 32'd1);
          check("rstmid_latency", 32'(cyc), 32'd5);
        end
        if (m0_ack3) drive(0, 0, 0, 16'h0, 8'h0);
        if (m1_ack3) drive(1, 0, 0, 16'h0, 8'h0);
      end
    end
    check("rstmid_ack_count", 32'(acks), 32'd2);
    tick();

    // Back-to-back transactions from one master holding req
    reset_only(0);
    drive(0, 1, 0, 16'h1111, 8'h00);
    push(0, 0, 0, 16'h1111, 8'h83);
    tick();
    tick();
    check("b2b_first_ack", 32'(m0_ack0), 32'd1);
    m0_addr = 16'h2233;
    push(0, 0, 0, 16'h2233, 8'h92);
    tick();
    check("b2b_idle_gap", 32'(busy0), 32'd0);
    tick();
    check("b2b_fresh_addr", 32'({busy0, address_bus0}), 32'h1_2233);
    tick();
    check("b2b_second_ack", 32'(m0_ack0), 32'd1);
    drive(0, 0, 0, 16'h0, 8'h0);
    tick();
    check("b2b_rdata_hold", 32'(m0_rdata0), 32'h92);
    tick();

    check("sb_drain_d0", 32'(q0.size()), 32'd0);
    check("sb_drain_d3", 32'(q3.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
